bg_compositor: RTL
==================

Name: bg_compositor

Overview:
- Sits directly downstream of the green-screen keyer in the D8M camera-to-VGA pixel path.
- Detects the keyer's marker pixel, {R[7:0],G[7]} = 0 and {G[6:0],B[7:0]} all ones (24'h007FFF), and replaces each marked pixel with a generated background.
- Tracks x/y from DE/VS, delays syncs to stay aligned, and reports the replaced-pixel count per frame.

Parameters:
- KEY_MARK, 24'h007FFF, exact pixel value treated as "keyed".
- VS_ACTIVE, 1'b0, level of vs_in that means vertical sync is asserted.
- BAR_SHIFT, 7, log2 of colour-bar width in pixels.
- CNT_W, 19, width of key_count; must hold 640x480.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- comp_en, input, 1, 1 = replace keyed pixels; 0 = pixels pass unchanged (still delayed).
- bg_sel, input, 2, background mode.
- bg_color, input, 24, solid/checker base colour, {R,G,B}.
- pixel_in, input, 24, keyer output pixel.
- de_in, input, 1, active-video enable.
- hs_in, input, 1, horizontal sync (polarity-agnostic, delayed only).
- vs_in, input, 1, vertical sync.
- pixel_out, output, 24, composited pixel.
- de_out, output, 1, de_in delayed 2 clocks.
- hs_out, output, 1, hs_in delayed 2 clocks.
- vs_out, output, 1, vs_in delayed 2 clocks.
- key_count, output, CNT_W, keyed pixels replaced in the previous frame.

Behaviour:
- Reset, asynchronous, active low: pixel_out=0, de_out=0, hs_out=0, vs_out=~VS_ACTIVE, key_count=0, x=0, y=0, all pipeline stages cleared with DE=0.
- Latency:
  - pixel_in/de_in/hs_in/vs_in sampled at edge t appear on outputs after edge t+2.
  - Latency is fixed at 2 whether or not comp_en or the optional feature is set.
- Counters (10-bit):
  - x increments on each de_in=1 cycle.
  - x clears on the cycle after de_in falls (1->0).
  - y increments on each de_in falling edge.
  - y clears while vs_in==VS_ACTIVE.
  - x and y saturate at 1023; they do not wrap.
  - x,y are captured with the pixel so the background uses that pixel's own coordinates.
- Key flag k = de && (pixel == KEY_MARK). With comp_en=0, k is forced to 0.
- Background by bg_sel:
  - 0: solid bg_color.
  - 1: colour bars, index = x[BAR_SHIFT+2:BAR_SHIFT]; 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2: checker, x[5]^y[5] ? ~bg_color : bg_color.
  - 3: gradient, {x[9:2], y[8:1], 8'h80}.
- Output selection:
  - Replace only when the final key decision is 1 and delayed DE=1.
  - Otherwise output the delayed pixel unchanged.
  - Blanking pixels (DE=0) are passed through unchanged, never replaced.
- key_count:
  - An internal counter increments per replaced pixel.
  - On the vs_in transition into VS_ACTIVE, key_count latches the counter and the counter clears, with the same edge taking precedence over a simultaneous increment (that pixel starts the new count). Since DE=0 during sync, no real collision is expected.
  - The counter saturates at all ones.
- comp_en and bg_sel are sampled per pixel; changing them mid-line affects only pixels sampled afterwards.
- Reset asserted mid-line: all state clears immediately; after release the first output is valid 2 clocks after the first sampled input; y stays 0 until the next DE falling edge.

Optional Feature:
- Macro BG_COMPOSITOR_DESPECKLE_EN.
- Defined: the final key for pixel n is the majority of k(n-1), k(n), k(n+1) within the same active run.
  - A neighbour outside the run (its DE=0) is replaced by k(n).
  - Net effect: isolated single keyed pixels are not replaced; single unkeyed holes inside keyed areas are replaced; line-edge pixels keep their own flag.
  - The n+1 lookahead uses the existing 2-stage pipeline; latency stays 2.
- Undefined: final key = k(n). Outputs are cycle-identical to the despeckle build whenever no isolated flag exists.

Test Plan:
- Reset mid-stream: rst_n low for 3 clocks during DE -> all outputs at reset values immediately; first 2 clocks after release show DE=0; key_count=0.
- Solid mode: bg_sel=0, bg_color=24'h123456, line of 8 KEY_MARK pixels -> 8 outputs of 123456, each 2 clocks after its input; de/hs/vs shifted exactly 2.
- Colour bars: bg_sel=1, full 640-pixel KEY_MARK line -> x=0..127 gives FFFFFF, x=128 gives FFFF00, x=512..639 gives FF00FF; x clears after DE falls.
- Pass-through: comp_en=0, KEY_MARK input -> pixel_out=007FFF; non-marker 24'hA0B0C0 with comp_en=1 -> unchanged.
- Frame count: 300 keyed pixels in frame 1, then VS asserted -> key_count=300; frame 2 with 0 keyed -> key_count=0 after the next VS.
- Despeckle (macro on): pattern 0,1,0 keyed -> nothing replaced; 1,0,1 -> all three replaced; keyed pixel at x=0 with x=1 keyed -> replaced.

Source files
------------

// File: rtl/bg_compositor.sv
// bg_compositor: replaces keyer-marked pixels with a generated background.
//
// Sits after the green-screen keyer. Any active pixel equal to KEY_MARK is
// swapped for a solid colour, colour bars, a checker or a gradient chosen by
// bg_sel, using that pixel's own x/y. Video and syncs are delayed by a fixed
// two clocks, and key_count reports how many pixels were replaced in the
// previous frame.
//
// Optional build macro: BG_COMPOSITOR_DESPECKLE_EN
//   When defined, the final key of a pixel is the majority vote of its own
//   flag and its left/right neighbours in the same active run, which drops
//   isolated keyed pixels and fills isolated holes. Latency is unchanged.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   comp_en           1 = replace keyed pixels, 0 = pass everything through
//   bg_sel[1:0]       0 solid, 1 colour bars, 2 checker, 3 gradient
//   bg_color[23:0]    solid/checker base colour {R,G,B}
//   pixel_in[23:0]    keyer output pixel
//   de_in/hs_in/vs_in active-video enable and syncs
//   pixel_out[23:0]   composited pixel (2 clocks after pixel_in)
//   de_out/hs_out/vs_out  syncs delayed 2 clocks
//   key_count         replaced pixels in the previous frame

module bg_compositor #(
    parameter logic [23:0] KEY_MARK  = 24'h007FFF,
    parameter logic        VS_ACTIVE = 1'b0,
    parameter int unsigned BAR_SHIFT = 7,
    parameter int unsigned CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             comp_en,
    input  logic [1:0]       bg_sel,
    input  logic [23:0]      bg_color,
    input  logic [23:0]      pixel_in,
    input  logic             de_in,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [23:0]      pixel_out,
    output logic             de_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic [CNT_W-1:0] key_count
);

    localparam int unsigned XY_W   = 10;
    localparam logic [XY_W-1:0] XY_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One pixel travelling down the pipeline with everything needed later.
    typedef struct packed {
        logic [23:0]     pix;
        logic            de;
        logic            hs;
        logic            vs;
        logic            k;
        logic [1:0]      sel;
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
    } stage_t;

    localparam stage_t STAGE_RST = '{
        pix: 24'h0, de: 1'b0, hs: 1'b0, vs: ~VS_ACTIVE, k: 1'b0,
        sel: 2'd0, x: '0, y: '0
    };

    logic [XY_W-1:0]  x_q, x_d;
    logic [XY_W-1:0]  y_q, y_d;
    stage_t           s1_q, s1_d;
    stage_t           s2_q;
    logic [23:0]      pixel_out_q, pixel_out_d;
    logic             de_out_q;
    logic             hs_out_q;
    logic             vs_out_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] key_count_q, key_count_d;

    logic             key_c;
    logic             replace_c;
    logic             vs_start_c;
    logic [23:0]      bg_c;

    // Fixed colour-bar palette.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Saturating x/y counters; s1_q.de is de_in from the previous clock.
    always_comb begin : coord_next
        x_d = x_q;
        y_d = y_q;
        if (de_in) begin
            if (x_q != XY_MAX) x_d = x_q + XY_W'(1);
        end else if (s1_q.de) begin
            x_d = '0;
        end
        if (vs_in == VS_ACTIVE) begin
            y_d = '0;
        end else if (!de_in && s1_q.de && (y_q != XY_MAX)) begin
            y_d = y_q + XY_W'(1);
        end
    end

    // Input capture: the key flag and coordinates belong to this pixel.
    always_comb begin : stage1_next
        s1_d     = STAGE_RST;
        s1_d.pix = pixel_in;
        s1_d.de  = de_in;
        s1_d.hs  = hs_in;
        s1_d.vs  = vs_in;
        s1_d.k   = comp_en && de_in && (pixel_in == KEY_MARK);
        s1_d.sel = bg_sel;
        s1_d.x   = x_q;
        s1_d.y   = y_q;
    end

`ifdef BG_COMPOSITOR_DESPECKLE_EN
    logic k3_q;
    logic kp_c;
    logic kn_c;

    // Majority of left/own/right flag; s1 holds the right neighbour, k3/de_out
    // the left one. A neighbour outside the run votes with the centre pixel.
    always_comb begin : key_vote
        kp_c  = de_out_q ? k3_q : s2_q.k;
        kn_c  = s1_q.de ? s1_q.k : s2_q.k;
        key_c = (kp_c & s2_q.k) | (kp_c & kn_c) | (s2_q.k & kn_c);
    end
`else
    always_comb begin : key_vote
        key_c = s2_q.k;
    end
`endif

    // Background generator from the pixel's own coordinates.
    always_comb begin : bg_gen
        bg_c = bg_color;
        case (s2_q.sel)
            2'd0:    bg_c = bg_color;
            2'd1:    bg_c = bar_color(s2_q.x[BAR_SHIFT+2:BAR_SHIFT]);
            2'd2:    bg_c = (s2_q.x[5] ^ s2_q.y[5]) ? ~bg_color : bg_color;
            default: bg_c = {s2_q.x[9:2], s2_q.y[8:1], 8'h80};
        endcase
    end

    // Output select and per-frame replace counter.
    always_comb begin : out_next
        replace_c   = key_c && s2_q.de;
        pixel_out_d = replace_c ? bg_c : s2_q.pix;
        vs_start_c  = (vs_in == VS_ACTIVE) && (s1_q.vs != VS_ACTIVE);
        cnt_d       = cnt_q;
        key_count_d = key_count_q;
        if (replace_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        // Frame boundary wins; a pixel replaced on this edge opens the new count.
        if (vs_start_c) begin
            key_count_d = cnt_q;
            cnt_d       = replace_c ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            s1_q        <= STAGE_RST;
            s2_q        <= STAGE_RST;
            pixel_out_q <= '0;
            de_out_q    <= 1'b0;
            hs_out_q    <= 1'b0;
            vs_out_q    <= ~VS_ACTIVE;
            cnt_q       <= '0;
            key_count_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            s1_q        <= s1_d;
            s2_q        <= s1_q;
            pixel_out_q <= pixel_out_d;
            de_out_q    <= s2_q.de;
            hs_out_q    <= s2_q.hs;
            vs_out_q    <= s2_q.vs;
            cnt_q       <= cnt_d;
            key_count_q <= key_count_d;
        end
    end

`ifdef BG_COMPOSITOR_DESPECKLE_EN
    always_ff @(posedge clk or negedge rst_n) begin : left_flag
        if (!rst_n) k3_q <= 1'b0;
        else        k3_q <= s2_q.k;
    end
`endif

    // Coordinate bits the background modes never look at.
    logic unused_xy_bits;
    assign unused_xy_bits = ^{s2_q.x[1:0], s2_q.y[9], s2_q.y[0]};

    assign pixel_out = pixel_out_q;
    assign de_out    = de_out_q;
    assign hs_out    = hs_out_q;
    assign vs_out    = vs_out_q;
    assign key_count = key_count_q;

endmodule
